imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Registered, parametrised immediate-generation stage for the pipelined RV core's decode path. It accepts one instruction and its PC per handshake and produces:
- the XLEN-wide sign-extended immediate
- a format code
- a precomputed PC+imm target for the branch predictor
- a control-transfer flag and an illegal-opcode flag

Outputs go through a 2-entry skid buffer, so backpressure never causes a combinational ready path from downstream to upstream.

Parameters:
XLEN, 32, datapath width for immediate, PC and target (legal values 32 or 64).
RESET_PC_TAG, 0, value driven on o_target and o_imm while o_valid is low and after reset.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_flush  input  1  synchronous pipeline flush; drops all held entries.
i_valid  input  1  upstream entry valid.
o_ready  output  1  stage can accept; registered.
i_instr  input  32  raw instruction word.
i_pc  input  XLEN  PC of i_instr.
o_valid  output  1  output entry valid.
i_ready  input  1  downstream accepts.
o_imm  output  XLEN  sign-extended immediate.
o_fmt  output  3  format code: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (CSR uimm), 7=NONE.
o_target  output  XLEN  i_pc + o_imm, modulo 2^XLEN.
o_is_ctrl  output  1  1 for B-type and JAL.
o_illegal  output  1  instruction not decodable.

Behaviour:
- Reset (i_rst_n low, async): o_valid=0, o_ready=1, o_imm=o_target=RESET_PC_TAG, o_fmt=7, o_is_ctrl=0, o_illegal=0, FSM to EMPTY.
- Decode by opcode[6:0]:
  - 0010011/0000011/1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111/0010111 → U.
  - 1101111 → J.
  - 0110011/0001111/1110011 → NONE, imm=0.
- Any other opcode, or instr[1:0]!=11 → NONE, imm=0, o_illegal=1. There is no default-to-I fallback.
- Sign extension:
  - I/S/B/J extend from instr[31] to XLEN.
  - U places instr[31:12]<<12 and sign-extends from bit 31 when XLEN=64.
  - B and J bit 0 is always 0.
- o_target is always pc+imm, and is meaningful only for B, J and AUIPC. JALR target is not computed here.
- Latency: 1 cycle from accept (i_valid&&o_ready) to o_valid when the stage was EMPTY.
- FSM:
  - EMPTY: accept → ONE.
  - ONE: output register valid.
    - accept && !i_ready → TWO (new entry into skid).
    - accept && i_ready → ONE (output replaced).
    - !accept && i_ready → EMPTY.
  - TWO: skid full, o_ready=0.
    - i_ready → ONE (skid moves to output).
- o_ready = (state!=TWO), registered from next state.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.
- i_flush has priority over every handshake in the same cycle: next state EMPTY, o_valid=0, o_ready=1, and any same-cycle input is discarded.
- An output entry's fields stay stable while o_valid && !i_ready.
- Reset asserted mid-transfer discards all entries immediately.

Optional Feature:
Macro IMM_CSR_UIMM_EN.
- Defined: opcode 1110011 with funct3 in {101,110,111} → fmt=5 (Z), o_imm = zero-extended instr[19:15], o_target=pc+imm. Other funct3 values under that opcode give NONE.
- Undefined: all 1110011 instructions → NONE, imm=0, not illegal. Encoding 5 is never produced.

Test Plan:
- Reset then idle → o_valid=0, o_ready=1, o_fmt=7, o_imm=0.
- pc=0x100, instr 0xFE000EE3 (beq -4), i_ready=1 → next cycle o_imm=0xFFFFFFFC, o_fmt=2, o_target=0x000000FC, o_is_ctrl=1.
- Back-to-back sequence with i_ready=1, each checked in order:
  - 0x001000EF (jal +2048) → imm 0x00000800, fmt=4.
  - 0x123452B7 (lui) → imm 0x12345000, fmt=3.
  - 0xFFF00093 (addi -1) → imm 0xFFFFFFFF, fmt=0.
- Backpressure: i_ready=0, push the three instrs above → first two accepted, o_ready low after the second, third held off. Release i_ready → outputs in order, o_ready returns high.
- instr 0x00000000 → o_illegal=1, o_fmt=7, o_imm=0. Assert i_flush while in TWO → o_valid=0 and o_ready=1 next cycle, held entries never appear.
- 0x3002D0F3 (csrrwi x1,0x300,5) → with IMM_CSR_UIMM_EN: fmt=5, imm=5. Without: fmt=7, imm=0, o_illegal=0. XLEN=64 run: addi -1 → imm 0xFFFFFFFFFFFFFFFF.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV immediate generator with 2-entry skid output
// Optional CSR uimm (Z format) decode: define IMM_CSR_UIMM_EN.
module imm_gen_pipe #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_PC_TAG = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic [XLEN-1:0] o_target,
    output logic            o_is_ctrl,
    output logic            o_illegal
);

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
`ifdef IMM_CSR_UIMM_EN
    localparam logic [2:0] FMT_Z    = 3'd5;
`endif
    localparam logic [2:0] FMT_NONE = 3'd7;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            is_ctrl;
        logic            illegal;
    } entry_t;

    logic [1:0] state_q, state_d;
    logic       ready_q, ready_d;
    logic       valid_q, valid_d;
    entry_t     out_q, out_d;
    entry_t     skid_q, skid_d;

    entry_t          idle_e;
    entry_t          dec_e;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [6:0]      opcode;
    logic            accept;

    assign opcode = i_instr[6:0];
    assign accept = i_valid && ready_q;

    // Every legal opcode ends in 2'b11, so a compressed-looking word falls to default.
    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_fmt = FMT_I;
                dec_imm = XLEN'($signed(i_instr[31:20]));
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                         i_instr[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                         i_instr[30:21], 1'b0}));
            end
            7'b0110011, 7'b0001111: begin
                dec_fmt = FMT_NONE;
            end
            7'b1110011: begin
`ifdef IMM_CSR_UIMM_EN
                if (i_instr[14] && (i_instr[13:12] != 2'b00)) begin
                    dec_fmt = FMT_Z;
                    dec_imm = XLEN'(i_instr[19:15]);
                end
`else
                dec_fmt = FMT_NONE;
`endif
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        dec_e.imm     = dec_imm;
        dec_e.target  = i_pc + dec_imm;
        dec_e.fmt     = dec_fmt;
        dec_e.is_ctrl = (dec_fmt == FMT_B) || (dec_fmt == FMT_J);
        dec_e.illegal = dec_illegal;

        idle_e.imm     = RESET_PC_TAG;
        idle_e.target  = RESET_PC_TAG;
        idle_e.fmt     = FMT_NONE;
        idle_e.is_ctrl = 1'b0;
        idle_e.illegal = 1'b0;
    end

    // The output register always holds the oldest entry; the skid only fills
    // when a new entry arrives while the output is stalled.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_d   = dec_e;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && i_ready) begin
                    out_d = dec_e;
                end else if (accept) begin
                    skid_d  = dec_e;
                    state_d = ST_TWO;
                end else if (i_ready) begin
                    out_d   = idle_e;
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (i_ready) begin
                    out_d   = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                out_d   = idle_e;
                state_d = ST_EMPTY;
            end
        endcase
        if (i_flush) begin
            out_d   = idle_e;
            state_d = ST_EMPTY;
        end
        ready_d = (state_d != ST_TWO);
        valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            out_q   <= '{imm: RESET_PC_TAG, target: RESET_PC_TAG, fmt: FMT_NONE,
                         is_ctrl: 1'b0, illegal: 1'b0};
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = valid_q;
    assign o_imm     = out_q.imm;
    assign o_target  = out_q.target;
    assign o_fmt     = out_q.fmt;
    assign o_is_ctrl = out_q.is_ctrl;
    assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe (XLEN=32 and XLEN=64 instances)
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [31:0] imm;
        logic [31:0] target;
        logic [2:0]  fmt;
        logic        ctrl;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_instr = '0;
    logic [31:0] i_pc = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_imm;
    logic [2:0]  o_fmt;
    logic [31:0] o_target;
    logic        o_is_ctrl;
    logic        o_illegal;

    logic        flush64 = 1'b0;
    logic        valid64 = 1'b0;
    logic        ready_o64;
    logic [31:0] instr64 = '0;
    logic [63:0] pc64 = '0;
    logic        valid_o64;
    logic        ready64 = 1'b1;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [63:0] target64;
    logic        ctrl64;
    logic        ill64;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    logic        hold_pending = 1'b0;
    logic [31:0] hold_imm;
    logic [2:0]  hold_fmt;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .RESET_PC_TAG(32'h0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready), .i_instr(i_instr), .i_pc(i_pc), .o_valid(o_valid),
        .i_ready(i_ready), .o_imm(o_imm), .o_fmt(o_fmt), .o_target(o_target),
        .o_is_ctrl(o_is_ctrl), .o_illegal(o_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .RESET_PC_TAG(64'h0)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush64), .i_valid(valid64),
        .o_ready(ready_o64), .i_instr(instr64), .i_pc(pc64), .o_valid(valid_o64),
        .i_ready(ready64), .o_imm(imm64), .o_fmt(fmt64), .o_target(target64),
        .o_is_ctrl(ctrl64), .o_illegal(ill64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] imm, input logic [2:0] fmt,
                                input logic ctrl, input logic ill, input logic [31:0] pc);
        exp_t e;
        e.imm    = imm;
        e.target = pc + imm;
        e.fmt    = fmt;
        e.ctrl   = ctrl;
        e.ill    = ill;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_instr = instr;
        i_pc    = pc;
        @(negedge clk);
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 64'd0, 64'd1);
        else exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        i_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pending && o_valid) begin
                check("stable_imm", o_imm, hold_imm);
                check("stable_fmt", o_fmt, hold_fmt);
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("imm", o_imm, e.imm);
                    check("fmt", o_fmt, e.fmt);
                    check("target", o_target, e.target);
                    check("is_ctrl", o_is_ctrl, e.ctrl);
                    check("illegal", o_illegal, e.ill);
                end
            end
            hold_pending = o_valid && !i_ready;
            hold_imm     = o_imm;
            hold_fmt     = o_fmt;
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        int n;
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 1);
        check("rst_fmt", o_fmt, 7);
        check("rst_imm", o_imm, 0);
        check("rst_target", o_target, 0);
        check("rst_ctrl", o_is_ctrl, 0);
        check("rst_illegal", o_illegal, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(2);
        check("idle_valid", o_valid, 0);
        check("idle_ready", o_ready, 1);

        i_ready = 1'b1;
        send(32'hFE000EE3, 32'h100, mk(32'hFFFFFFFC, 3'd2, 1'b1, 1'b0, 32'h100));
        check("latency_valid", o_valid, 1);
        idle_cycles(3);

        send(32'h001000EF, 32'h200, mk(32'h00000800, 3'd4, 1'b1, 1'b0, 32'h200));
        send(32'h123452B7, 32'h204, mk(32'h12345000, 3'd3, 1'b0, 1'b0, 32'h204));
        send(32'hFFF00093, 32'h208, mk(32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 32'h208));
        send(32'hFE112E23, 32'h20C, mk(32'hFFFFFFFC, 3'd1, 1'b0, 1'b0, 32'h20C));
        send(32'h002081B3, 32'h210, mk(32'h0, 3'd7, 1'b0, 1'b0, 32'h210));
        send(32'h00000000, 32'h214, mk(32'h0, 3'd7, 1'b0, 1'b1, 32'h214));
        send(32'hFFF00091, 32'h218, mk(32'h0, 3'd7, 1'b0, 1'b1, 32'h218));
        send(32'h80000017, 32'h21C, mk(32'h80000000, 3'd3, 1'b0, 1'b0, 32'h21C));
`ifdef IMM_CSR_UIMM_EN
        send(32'h3002D0F3, 32'h220, mk(32'h5, 3'd5, 1'b0, 1'b0, 32'h220));
`else
        send(32'h3002D0F3, 32'h220, mk(32'h0, 3'd7, 1'b0, 1'b0, 32'h220));
`endif
        send(32'h300090F3, 32'h224, mk(32'h0, 3'd7, 1'b0, 1'b0, 32'h224));
        idle_cycles(3);
        check("b2b_drained", exp_q.size(), 0);

        i_ready = 1'b0;
        send(32'h001000EF, 32'h300, mk(32'h00000800, 3'd4, 1'b1, 1'b0, 32'h300));
        send(32'h123452B7, 32'h304, mk(32'h12345000, 3'd3, 1'b0, 1'b0, 32'h304));
        i_valid = 1'b1;
        i_instr = 32'hFFF00093;
        i_pc    = 32'h308;
        @(negedge clk);
        check("bp_ready_low", o_ready, 0);
        check("bp_valid", o_valid, 1);
        check("bp_head_imm", o_imm, 32'h00000800);
        repeat (2) @(negedge clk);
        check("bp_ready_still_low", o_ready, 0);
        @(posedge clk); #1;
        i_ready = 1'b1;
        send(32'hFFF00093, 32'h308, mk(32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 32'h308));
        idle_cycles(4);
        check("bp_ready_back", o_ready, 1);
        check("bp_drained", exp_q.size(), 0);

        i_ready = 1'b0;
        send(32'hFE000EE3, 32'h400, mk(32'hFFFFFFFC, 3'd2, 1'b1, 1'b0, 32'h400));
        send(32'h00000000, 32'h404, mk(32'h0, 3'd7, 1'b0, 1'b1, 32'h404));
        exp_q.delete();
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_instr = 32'hFFF00093;
        @(posedge clk); #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", o_valid, 0);
        check("flush_ready", o_ready, 1);
        check("flush_fmt", o_fmt, 7);
        @(posedge clk); #1;
        i_flush = 1'b1;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        check("flush_discard_input", o_valid, 0);
        @(posedge clk); #1;
        i_ready = 1'b1;
        idle_cycles(5);
        check("flush_no_output", o_valid, 0);

        i_ready = 1'b0;
        send(32'h001000EF, 32'h500, mk(32'h00000800, 3'd4, 1'b1, 1'b0, 32'h500));
        send(32'h123452B7, 32'h504, mk(32'h12345000, 3'd3, 1'b0, 1'b0, 32'h504));
        i_valid = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", o_valid, 0);
        check("midrst_ready", o_ready, 1);
        check("midrst_imm", o_imm, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_ready = 1'b1;
        idle_cycles(4);
        check("midrst_no_output", o_valid, 0);

        valid64 = 1'b1;
        instr64 = 32'hFFF00093;
        pc64    = 64'h1000;
        @(posedge clk); #1;
        valid64 = 1'b0;
        @(negedge clk);
        check("x64_valid", valid_o64, 1);
        check("x64_addi_imm", imm64, 64'hFFFFFFFFFFFFFFFF);
        check("x64_addi_target", target64, 64'h0FFF);
        check("x64_addi_fmt", fmt64, 0);
        @(posedge clk); #1;
        valid64 = 1'b1;
        instr64 = 32'h800000B7;
        @(posedge clk); #1;
        valid64 = 1'b0;
        @(negedge clk);
        check("x64_lui_imm", imm64, 64'hFFFFFFFF80000000);
        check("x64_lui_fmt", fmt64, 3);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("final_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
